// File: rtl/tron_imem_server.sv
// -----------------------------------------------------------------------------
// tron_imem_server
//
// Instruction memory for the Tron core. A host first streams a program image
// in over a valid/ready port. The block then serves the core's fetches and
// stores out of a 2**ADDR_W x 16-bit word memory.
//
// Optional feature (compile-time macro TRON_IMEM_CHECKSUM_EN):
//   Each load carries one extra trailing word. That word is a 16-bit wrapping
//   checksum of the data words. It is never written to memory. A bad checksum
//   pulses ld_done, sets the sticky ld_csum_err and leaves the block in IDLE.
//
// Ports:
//   clk          in   rising-edge system clock
//   reset        in   asynchronous active-low reset
//   cpu_addr     in   [15:0] fetch/store word address from the core
//   cpu_wdata    in   [15:0] store data from the core
//   cpu_we       in   store strobe (honoured only while serving)
//   instruction  out  [15:0] registered fetch result; NOP_WORD while stalled
//   cpu_stall    out  core holds its PC while high
//   ld_start     in   one-cycle pulse starting a load (also a reload from SERVE)
//   ld_len       in   [ADDR_W:0] word count, sampled with ld_start
//   ld_valid     in   loader word valid
//   ld_data      in   [15:0] loader word
//   ld_ready     out  block accepts ld_data (high for the whole LOAD state)
//   ld_done      out  one-cycle pulse after the final load word is accepted
//   addr_err     out  sticky: out-of-range fetch or store seen while serving
//   ld_csum_err  out  sticky checksum mismatch (TRON_IMEM_CHECKSUM_EN only)
//   dbg_state    out  [1:0] FSM state: 0 IDLE, 1 LOAD, 2 SERVE
//
// Handshake: a loader word transfers on a rising edge where ld_valid and
// ld_ready are both high. ld_ready does not depend on ld_valid. The host may
// hold or change ld_data freely while ld_valid is low.
// -----------------------------------------------------------------------------
module tron_imem_server #(
    parameter int          ADDR_W   = 8,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       cpu_addr,
    input  logic [15:0]       cpu_wdata,
    input  logic              cpu_we,
    output logic [15:0]       instruction,
    output logic              cpu_stall,
    input  logic              ld_start,
    input  logic [ADDR_W:0]   ld_len,
    input  logic              ld_valid,
    input  logic [15:0]       ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              addr_err,
`ifdef TRON_IMEM_CHECKSUM_EN
    output logic              ld_csum_err,
`endif
    output logic [1:0]        dbg_state
);

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SERVE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [ADDR_W:0] r_len;
    logic [ADDR_W:0] r_count;
    logic [15:0]     r_instr;
    logic            r_ld_done;
    logic            r_addr_err;
    logic [15:0]     r_mem [DEPTH];

    logic [ADDR_W:0] w_len_clamped;
    logic            w_start_load;
    logic            w_accept;
    logic            w_load_write;
    logic            w_done_set;
    logic            w_addr_oor;
    logic            w_serve_store;

`ifdef TRON_IMEM_CHECKSUM_EN
    logic [15:0]     r_sum;
    logic            r_csum_err;
    logic            w_csum_word;
    logic            w_csum_fail;
`endif

    // Any address bit at or above ADDR_W set means the word lies outside the memory.
    assign w_addr_oor    = |(cpu_addr >> ADDR_W);
    assign w_serve_store = (r_state == S_SERVE) && cpu_we && !w_addr_oor;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start_load = 1'b0;
        w_accept     = 1'b0;
        w_load_write = 1'b0;
        w_done_set   = 1'b0;
`ifdef TRON_IMEM_CHECKSUM_EN
        w_csum_word  = 1'b0;
        w_csum_fail  = 1'b0;
`endif
        // A length with the top bit set is at least DEPTH, so it clamps to DEPTH.
        w_len_clamped = ld_len[ADDR_W] ? MAX_LEN : ld_len;

        case (r_state)
            S_IDLE, S_SERVE: begin
                if (ld_start) begin
                    w_start_load = 1'b1;
`ifdef TRON_IMEM_CHECKSUM_EN
                    // A zero-length load still expects its checksum word.
                    w_next_state = S_LOAD;
`else
                    if (w_len_clamped == '0) begin
                        w_next_state = S_SERVE;
                        w_done_set   = 1'b1;
                    end else begin
                        w_next_state = S_LOAD;
                    end
`endif
                end
            end
            S_LOAD: begin
                w_accept = ld_valid;
`ifdef TRON_IMEM_CHECKSUM_EN
                w_csum_word  = (r_count == r_len);
                w_load_write = w_accept && !w_csum_word;
                if (w_accept && w_csum_word) begin
                    w_done_set  = 1'b1;
                    w_csum_fail = (ld_data != r_sum);
                    w_next_state = w_csum_fail ? S_IDLE : S_SERVE;
                end
`else
                w_load_write = w_accept;
                if (w_accept && (r_count == r_len - ONE)) begin
                    w_done_set   = 1'b1;
                    w_next_state = S_SERVE;
                end
`endif
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------ datapath regs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len      <= '0;
            r_count    <= '0;
            r_instr    <= NOP_WORD;
            r_ld_done  <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            if (w_start_load) begin
                r_len   <= w_len_clamped;
                r_count <= '0;
            end else if (w_accept) begin
                r_count <= r_count + ONE;
            end
            r_ld_done <= w_done_set;
            // Capture a fetch only when serving this cycle and the next. Leaving
            // SERVE therefore puts NOP_WORD on the output together with the stall.
            if ((r_state == S_SERVE) && (w_next_state == S_SERVE) && !w_addr_oor) begin
                r_instr <= r_mem[cpu_addr[ADDR_W-1:0]];
            end else begin
                r_instr <= NOP_WORD;
            end
            if ((r_state == S_SERVE) && w_addr_oor) begin
                r_addr_err <= 1'b1;
            end
        end
    end

`ifdef TRON_IMEM_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sum      <= '0;
            r_csum_err <= 1'b0;
        end else begin
            if (w_start_load) begin
                r_sum <= '0;
            end else if (w_load_write) begin
                r_sum <= r_sum + ld_data;
            end
            if (w_csum_fail) begin
                r_csum_err <= 1'b1;
            end
        end
    end

    assign ld_csum_err = r_csum_err;
`endif

    // Memory has no reset, so contents survive a reset mid-load. Load writes
    // and core stores occur in different states, so they never collide.
    always_ff @(posedge clk) begin
        if (w_load_write) begin
            r_mem[r_count[ADDR_W-1:0]] <= ld_data;
        end else if (w_serve_store) begin
            r_mem[cpu_addr[ADDR_W-1:0]] <= cpu_wdata;
        end
    end

    assign instruction = r_instr;
    assign cpu_stall   = (r_state != S_SERVE);
    assign ld_ready    = (r_state == S_LOAD);
    assign ld_done     = r_ld_done;
    assign addr_err    = r_addr_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_tron_imem_server.sv
module tb_tron_imem_server;

  localparam int ADDR_W = 8;

  logic              clk;
  logic              reset;
  logic [15:0]       cpu_addr;
  logic [15:0]       cpu_wdata;
  logic              cpu_we;
  logic [15:0]       instruction;
  logic              cpu_stall;
  logic              ld_start;
  logic [ADDR_W:0]   ld_len;
  logic              ld_valid;
  logic [15:0]       ld_data;
  logic              ld_ready;
  logic              ld_done;
  logic              addr_err;
`ifdef TRON_IMEM_CHECKSUM_EN
  logic              ld_csum_err;
`endif
  logic [1:0]        dbg_state;

  int n_vec;
  int n_err;
  int done_cnt;
  int ready_cnt;
  int snap;
  logic [15:0] exp_q[$];

  tron_imem_server #(.ADDR_W(ADDR_W), .NOP_WORD(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_we      (cpu_we),
    .instruction (instruction),
    .cpu_stall   (cpu_stall),
    .ld_start    (ld_start),
    .ld_len      (ld_len),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .ld_done     (ld_done),
    .addr_err    (addr_err),
`ifdef TRON_IMEM_CHECKSUM_EN
    .ld_csum_err (ld_csum_err),
`endif
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ld_done) done_cnt++;
    if (ld_ready) ready_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // checking
  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int len);
    ld_start = 1'b1;
    ld_len   = (ADDR_W + 1)'(len);
    tick();
    ld_start = 1'b0;
  endtask

  task automatic drive_word(input logic [15:0] w, input bit gap);
    int budget;
    if (gap) begin
      ld_valid = 1'b0;
      tick();
    end
    ld_valid = 1'b1;
    ld_data  = w;
    budget   = 0;
    while (!ld_ready && budget < 20) begin
      tick();
      budget++;
    end
    check_val("ld_ready_wait", 16'(ld_ready), 16'd1);
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic fetch(input logic [15:0] a, input string tag);
    cpu_addr = a;
    tick();
    check_val(tag, instruction, exp_q.pop_front());
  endtask

  task automatic check_done_serve(input string tag);
    check_val({tag, "_done"},  16'(ld_done),   16'd1);
    check_val({tag, "_ready"}, 16'(ld_ready),  16'd0);
    check_val({tag, "_stall"}, 16'(cpu_stall), 16'd0);
    check_val({tag, "_state"}, 16'(dbg_state), 16'd2);
  endtask

  initial begin
    n_vec = 0; n_err = 0; done_cnt = 0; ready_cnt = 0;
    reset = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
    ld_start = 1'b0; ld_len = '0; ld_valid = 1'b0; ld_data = '0;
    tick(); tick();

    // reset values
    check_val("rst_instr",    instruction,     16'h0000);
    check_val("rst_stall",    16'(cpu_stall),  16'd1);
    check_val("rst_ready",    16'(ld_ready),   16'd0);
    check_val("rst_done",     16'(ld_done),    16'd0);
    check_val("rst_addr_err", 16'(addr_err),   16'd0);
    check_val("rst_state",    16'(dbg_state),  16'd0);
`ifdef TRON_IMEM_CHECKSUM_EN
    check_val("rst_csum_err", 16'(ld_csum_err), 16'd0);
`endif
    reset = 1'b1;
    tick();

    // 3-word load, gapped valid
    snap = done_cnt;
    start_load(3);
    check_val("t1_ready", 16'(ld_ready),  16'd1);
    check_val("t1_stall", 16'(cpu_stall), 16'd1);
    drive_word(16'h1234, 1'b1);
    drive_word(16'hABCD, 1'b1);
    drive_word(16'h0F0F, 1'b1);
`ifdef TRON_IMEM_CHECKSUM_EN
    drive_word(16'hCD10, 1'b1);
`endif
    check_done_serve("t1");
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'hABCD);
    exp_q.push_back(16'h0F0F);
    fetch(16'd0, "t1_fetch0");
    check_val("t1_done_once", 16'(done_cnt - snap), 16'd1);
    fetch(16'd1, "t1_fetch1");
    fetch(16'd2, "t1_fetch2");

    // store and fetch to the same address in one cycle
    cpu_addr = 16'd5; cpu_wdata = 16'h5555; cpu_we = 1'b1;
    tick();
    cpu_wdata = 16'hBEEF;
    tick();
    cpu_we = 1'b0;
    check_val("t2_same_cycle_old", instruction, 16'h5555);
    exp_q.push_back(16'hBEEF);
    fetch(16'd5, "t2_new_data");

    // out-of-range fetch and store
    cpu_addr = 16'h0100;
    tick();
    check_val("t3_oor_nop",  instruction,    16'h0000);
    check_val("t3_addr_err", 16'(addr_err),  16'd1);
    cpu_wdata = 16'hDEAD; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    exp_q.push_back(16'h1234);
    fetch(16'd0, "t3_mem0_kept");
    check_val("t3_err_sticky", 16'(addr_err), 16'd1);

    // zero-length load
    snap = ready_cnt;
    start_load(0);
`ifdef TRON_IMEM_CHECKSUM_EN
    drive_word(16'h0000, 1'b0);
`else
    check_val("t4_no_ready", 16'(ready_cnt - snap), 16'd0);
`endif
    check_done_serve("t4");
    tick();
    check_val("t4_done_low", 16'(ld_done), 16'd0);

    // reload from SERVE, reset mid-load, fresh load
    cpu_addr = 16'd7; cpu_wdata = 16'h7070; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    exp_q.push_back(16'h1234);
    fetch(16'd0, "t5_pre_fetch");
    start_load(4);
    check_val("t5_reload_stall", 16'(cpu_stall), 16'd1);
    check_val("t5_reload_nop",   instruction,     16'h0000);
    cpu_addr = 16'd7; cpu_wdata = 16'hFFFF; cpu_we = 1'b1;
    drive_word(16'hAAAA, 1'b0);
    drive_word(16'hBBBB, 1'b0);
    cpu_we = 1'b0;
    reset = 1'b0;
    #1;
    check_val("t5_rst_state", 16'(dbg_state), 16'd0);
    check_val("t5_rst_stall", 16'(cpu_stall), 16'd1);
    check_val("t5_rst_ready", 16'(ld_ready),  16'd0);
    tick();
    reset = 1'b1;
    tick();
    start_load(4);
    drive_word(16'h1111, 1'b0);
    drive_word(16'h2222, 1'b0);
    drive_word(16'h3333, 1'b0);
    drive_word(16'h4444, 1'b0);
`ifdef TRON_IMEM_CHECKSUM_EN
    drive_word(16'hAAAA, 1'b0);
`endif
    check_done_serve("t5");
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    exp_q.push_back(16'h3333);
    exp_q.push_back(16'h4444);
    exp_q.push_back(16'h7070);
    fetch(16'd0, "t5_fetch0");
    fetch(16'd1, "t5_fetch1");
    fetch(16'd2, "t5_fetch2");
    fetch(16'd3, "t5_fetch3");
    fetch(16'd7, "t5_load_store_ignored");
    check_val("t5_addr_err_cleared", 16'(addr_err), 16'd0);

`ifdef TRON_IMEM_CHECKSUM_EN
    // bad checksum: 1 + 2 != 4
    start_load(2);
    drive_word(16'h0001, 1'b0);
    drive_word(16'h0002, 1'b0);
    drive_word(16'h0004, 1'b0);
    check_val("t6_done",     16'(ld_done),     16'd1);
    check_val("t6_state",    16'(dbg_state),   16'd0);
    check_val("t6_stall",    16'(cpu_stall),   16'd1);
    check_val("t6_csum_err", 16'(ld_csum_err), 16'd1);
    tick();
    check_val("t6_still_stalled", 16'(cpu_stall), 16'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
